// File: rtl/huffman_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : huffman_block_sequencer                                      |
// | Description : Steps one quantised, zig-zag ordered block through external  |
// |               DC/AC entropy-encoder lookup logic. Keeps a DC predictor per |
// |               colour component, waits ENC_LAT cycles for each encoder      |
// |               result and emits one codeword per symbol on a valid/ready    |
// |               stream toward the bit packer.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clock, reset          : single clock, synchronous active-high reset      |
// |   start, comp_id        : block start (accepted only when idle), component |
// |   dc_clear              : restart marker, zeroes all DC predictors (idle)  |
// |   block_in              : NUM_COEF coefficients, coef k at [k*COEF_W +:]   |
// |   busy                  : block in progress                                |
// |   is_luminance          : encoder table select (component 0)               |
// |   coef_matrix, dc_diff, ac_index : inputs to the encoder lookup logic      |
// |   enc_*                 : encoder results, valid ENC_LAT cycles after drive|
// |   out_*                 : codeword stream toward the bit packer            |
// | Optional feature (macro HUFF_BLOCK_STATS_EN)                               |
// |   stat_sym_count, stat_bit_count, stat_valid : per-block symbol/bit counts |
// +----------------------------------------------------------------------------+
module huffman_block_sequencer #(
   parameter int COEF_W   = 10,
   parameter int NUM_COEF = 64,
   parameter int NUM_COMP = 3,
   parameter int ENC_LAT  = 5,
   parameter int IDX_W    = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [1:0]                 comp_id,
   input  logic                       dc_clear,
   input  logic [NUM_COEF*COEF_W-1:0] block_in,
   output logic                       busy,
   output logic                       is_luminance,
   output logic [NUM_COEF*COEF_W-1:0] coef_matrix,
   output logic [COEF_W:0]            dc_diff,
   output logic [IDX_W-1:0]           ac_index,
   input  logic [15:0]                enc_dc_code,
   input  logic [4:0]                 enc_dc_len,
   input  logic [15:0]                enc_ac_code,
   input  logic [4:0]                 enc_ac_len,
   input  logic [3:0]                 enc_run,
   input  logic                       enc_eob,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                out_code,
   output logic [4:0]                 out_len,
   output logic                       out_is_dc,
`ifdef HUFF_BLOCK_STATS_EN
   output logic [6:0]                 stat_sym_count,
   output logic [10:0]                stat_bit_count,
   output logic                       stat_valid,
`endif
   output logic                       out_last
);

   localparam int CNT_W = (ENC_LAT < 2) ? 1 : $clog2(ENC_LAT + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_DC_WAIT  = 3'd2;
   localparam logic [2:0] S_DC_OUT   = 3'd3;
   localparam logic [2:0] S_AC_ISSUE = 3'd4;
   localparam logic [2:0] S_AC_WAIT  = 3'd5;
   localparam logic [2:0] S_AC_OUT   = 3'd6;

   logic [2:0]                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [1:0]                 comp_q, comp_d;
   logic [NUM_COEF*COEF_W-1:0] coef_q, coef_d;
   logic [COEF_W-1:0]          pred_q [NUM_COMP];
   logic [COEF_W-1:0]          pred_d [NUM_COMP];
   logic [COEF_W:0]            dc_diff_q, dc_diff_d;
   logic [IDX_W-1:0]           ac_index_q, ac_index_d;
   logic [IDX_W-1:0]           next_idx_q, next_idx_d;
   logic [15:0]                out_code_q, out_code_d;
   logic [4:0]                 out_len_q, out_len_d;
   logic                       out_valid_q, out_valid_d;
   logic                       out_is_dc_q, out_is_dc_d;
   logic                       out_last_q, out_last_d;
   logic                       busy_q, busy_d;
   logic                       is_lum_q, is_lum_d;

   logic                       w_hs;
   logic [1:0]                 w_comp;
   logic [COEF_W-1:0]          w_coef0;
   logic [COEF_W-1:0]          w_pred;
   logic [IDX_W:0]             w_next;

   assign w_hs    = out_valid_q & out_ready;
   assign w_comp  = (int'(comp_id) < NUM_COMP) ? comp_id : 2'd0;
   assign w_coef0 = coef_q[COEF_W-1:0];
   assign w_pred  = pred_q[comp_q];
   // One extra bit so an advance past the end of the block cannot wrap.
   assign w_next  = {1'b0, ac_index_q} + (IDX_W+1)'(enc_run) + (IDX_W+1)'(1);

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start) state_d = S_LOAD;
         S_LOAD:     state_d = S_DC_WAIT;
         S_DC_WAIT:  if (cnt_q == '0) state_d = S_DC_OUT;
         S_DC_OUT:   if (w_hs) state_d = S_AC_ISSUE;
         S_AC_ISSUE: state_d = S_AC_WAIT;
         S_AC_WAIT:  if (cnt_q == '0) state_d = S_AC_OUT;
         S_AC_OUT:   if (w_hs) state_d = out_last_q ? S_IDLE : S_AC_ISSUE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath / output logic
   always_comb begin
      cnt_d       = cnt_q;
      comp_d      = comp_q;
      coef_d      = coef_q;
      pred_d      = pred_q;
      dc_diff_d   = dc_diff_q;
      ac_index_d  = ac_index_q;
      next_idx_d  = next_idx_q;
      out_code_d  = out_code_q;
      out_len_d   = out_len_q;
      out_valid_d = out_valid_q;
      out_is_dc_d = out_is_dc_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      is_lum_d    = is_lum_q;
      case (state_q)
         S_IDLE: begin
            // Clear is applied here; the block reads its predictor in LOAD,
            // so a simultaneous start already sees the cleared value.
            if (dc_clear) begin
               for (int i = 0; i < NUM_COMP; i++) pred_d[i] = '0;
            end
            if (start) begin
               coef_d   = block_in;
               comp_d   = w_comp;
               is_lum_d = (w_comp == 2'd0);
               busy_d   = 1'b1;
            end
         end
         S_LOAD: begin
            dc_diff_d = {w_coef0[COEF_W-1], w_coef0} - {w_pred[COEF_W-1], w_pred};
            cnt_d     = CNT_W'(ENC_LAT);
         end
         S_DC_WAIT: begin
            if (cnt_q == '0) begin
               out_code_d  = enc_dc_code;
               out_len_d   = enc_dc_len;
               out_valid_d = 1'b1;
               out_is_dc_d = 1'b1;
               out_last_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DC_OUT: begin
            if (w_hs) begin
               pred_d[comp_q] = w_coef0;
               ac_index_d     = IDX_W'(1);
               out_valid_d    = 1'b0;
            end
         end
         S_AC_ISSUE: begin
            // ac_index is already on the encoder bus during this cycle, so it
            // counts toward the latency: wait one cycle less than for DC.
            cnt_d = CNT_W'(ENC_LAT - 1);
         end
         S_AC_WAIT: begin
            if (cnt_q == '0) begin
               out_code_d  = enc_ac_code;
               out_len_d   = enc_ac_len;
               out_valid_d = 1'b1;
               out_is_dc_d = 1'b0;
               out_last_d  = enc_eob | (w_next >= (IDX_W+1)'(NUM_COEF));
               next_idx_d  = w_next[IDX_W-1:0];
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_AC_OUT: begin
            if (w_hs) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  out_last_d = 1'b0;
                  busy_d     = 1'b0;
               end else begin
                  ac_index_d = next_idx_q;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q       <= '0;
         comp_q      <= '0;
         coef_q      <= '0;
         for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
         dc_diff_q   <= '0;
         ac_index_q  <= '0;
         next_idx_q  <= '0;
         out_code_q  <= '0;
         out_len_q   <= '0;
         out_valid_q <= 1'b0;
         out_is_dc_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         is_lum_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         comp_q      <= comp_d;
         coef_q      <= coef_d;
         pred_q      <= pred_d;
         dc_diff_q   <= dc_diff_d;
         ac_index_q  <= ac_index_d;
         next_idx_q  <= next_idx_d;
         out_code_q  <= out_code_d;
         out_len_q   <= out_len_d;
         out_valid_q <= out_valid_d;
         out_is_dc_q <= out_is_dc_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         is_lum_q    <= is_lum_d;
      end
   end

`ifdef HUFF_BLOCK_STATS_EN
   logic [6:0]  stat_sym_q, stat_sym_d;
   logic [10:0] stat_bit_q, stat_bit_d;
   logic        stat_valid_q, stat_valid_d;

   always_comb begin
      stat_sym_d   = stat_sym_q;
      stat_bit_d   = stat_bit_q;
      stat_valid_d = 1'b0;
      if (state_q == S_IDLE && start) begin
         stat_sym_d = '0;
         stat_bit_d = '0;
      end else if (w_hs) begin
         stat_sym_d   = stat_sym_q + 7'd1;
         stat_bit_d   = stat_bit_q + 11'(out_len_q);
         stat_valid_d = (state_q == S_AC_OUT) && out_last_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_sym_q   <= '0;
         stat_bit_q   <= '0;
         stat_valid_q <= 1'b0;
      end else begin
         stat_sym_q   <= stat_sym_d;
         stat_bit_q   <= stat_bit_d;
         stat_valid_q <= stat_valid_d;
      end
   end

   assign stat_sym_count = stat_sym_q;
   assign stat_bit_count = stat_bit_q;
   assign stat_valid     = stat_valid_q;
`endif

   assign busy         = busy_q;
   assign is_luminance = is_lum_q;
   assign coef_matrix  = coef_q;
   assign dc_diff      = dc_diff_q;
   assign ac_index     = ac_index_q;
   assign out_valid    = out_valid_q;
   assign out_code     = out_code_q;
   assign out_len      = out_len_q;
   assign out_is_dc    = out_is_dc_q;
   assign out_last     = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_huffman_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_huffman_block_sequencer                                   |
// | Description : Directed self-checking bench. A behavioural encoder model    |
// |               with ENC_LAT pipeline stages answers dc_diff/ac_index;       |
// |               a monitor logs every output handshake.                       |
// |               Codeword model: DC code = sign-extended dc_diff, len 9;      |
// |               AC code = {4'hA, run, k}, len run+1; ZRL 16'h07F9 len 11;    |
// |               EOB 16'h000A len 4.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_huffman_block_sequencer;
   localparam int COEF_W = 10, NUM_COEF = 64, NUM_COMP = 3, ENC_LAT = 5, IDX_W = 8;

   logic clock = 1'b0, reset = 1'b1, start = 1'b0, dc_clear = 1'b0, out_ready = 1'b1;
   logic [1:0] comp_id = 2'd0;
   logic [NUM_COEF*COEF_W-1:0] block_in;
   logic [COEF_W-1:0] tb_coef [NUM_COEF];
   logic busy, is_luminance, out_valid, out_is_dc, out_last;
   logic [NUM_COEF*COEF_W-1:0] coef_matrix;
   logic [COEF_W:0] dc_diff;
   logic [IDX_W-1:0] ac_index;
   logic [15:0] enc_dc_code, enc_ac_code, out_code;
   logic [4:0] enc_dc_len, enc_ac_len, out_len;
   logic [3:0] enc_run;
   logic enc_eob;
`ifdef HUFF_BLOCK_STATS_EN
   logic [6:0] stat_sym_count;
   logic [10:0] stat_bit_count;
   logic stat_valid;
`endif

   int checks = 0, errors = 0, n_log = 0;
   logic [30:0] lg [256];
   logic [10:0] lg_diff [256];

   huffman_block_sequencer #(.COEF_W(COEF_W), .NUM_COEF(NUM_COEF), .NUM_COMP(NUM_COMP),
                             .ENC_LAT(ENC_LAT), .IDX_W(IDX_W)) dut (
      .clock(clock), .reset(reset), .start(start), .comp_id(comp_id), .dc_clear(dc_clear),
      .block_in(block_in), .busy(busy), .is_luminance(is_luminance),
      .coef_matrix(coef_matrix), .dc_diff(dc_diff), .ac_index(ac_index),
      .enc_dc_code(enc_dc_code), .enc_dc_len(enc_dc_len), .enc_ac_code(enc_ac_code),
      .enc_ac_len(enc_ac_len), .enc_run(enc_run), .enc_eob(enc_eob),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_len(out_len),
      .out_is_dc(out_is_dc),
`ifdef HUFF_BLOCK_STATS_EN
      .stat_sym_count(stat_sym_count), .stat_bit_count(stat_bit_count), .stat_valid(stat_valid),
`endif
      .out_last(out_last));

   always #5 clock = ~clock;

   always_comb begin
      block_in = '0;
      for (int k = 0; k < NUM_COEF; k++) block_in[k*COEF_W +: COEF_W] = tb_coef[k];
   end

   // Encoder model: {dc_code, dc_len, ac_code, ac_len, run, eob}
   function automatic logic [46:0] enc_f(input logic [10:0] d, input logic [7:0] ix);
      logic [15:0] ac; logic [4:0] al; logic [3:0] rn; logic eb; int nz;
      nz = -1;
      for (int k = int'(ix); k < NUM_COEF; k++) if (nz < 0 && tb_coef[k] != 0) nz = k;
      if (nz < 0) begin
         ac = 16'h000A; al = 5'd4; rn = 4'd0; eb = 1'b1;
      end else if (nz - int'(ix) > 15) begin
         ac = 16'h07F9; al = 5'd11; rn = 4'd15; eb = 1'b0;
      end else begin
         rn = 4'(nz - int'(ix)); ac = {4'hA, rn, 8'(nz)}; al = 5'(nz - int'(ix) + 1); eb = 1'b0;
      end
      return {{5{d[10]}}, d, 5'd9, ac, al, rn, eb};
   endfunction

   logic [46:0] pipe [ENC_LAT];
   always @(posedge clock) begin
      pipe[0] <= enc_f(dc_diff, ac_index);
      for (int i = 1; i < ENC_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign {enc_dc_code, enc_dc_len, enc_ac_code, enc_ac_len, enc_run, enc_eob} = pipe[ENC_LAT-1];

   // Handshake log: {code, len, is_dc, last, index (0 for DC)}
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready && n_log < 256) begin
         lg[n_log]      = {out_code, out_len, out_is_dc, out_last, out_is_dc ? 8'd0 : ac_index};
         lg_diff[n_log] = dc_diff;
         n_log++;
      end
   end

   function automatic logic [30:0] mk(input logic [15:0] c, input int l, input bit d,
                                      input bit la, input int ix);
      return {c, 5'(l), d, la, 8'(ix)};
   endfunction

   task automatic clear_coefs();
      for (int k = 0; k < NUM_COEF; k++) tb_coef[k] = '0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (!busy) return;
      end
      checks++; errors++;
      $display("FAIL idle_timeout busy=%0b required 0", busy);
   endtask

   task automatic run_block(input int comp, input bit clr, output int base);
      base = n_log;
      @(posedge clock); #1; start = 1'b1; comp_id = 2'(comp); dc_clear = clr;
      @(posedge clock); #1; start = 1'b0; dc_clear = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({busy, out_valid, out_last, out_is_dc, is_luminance} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got=%b required 00000",
                            {busy, out_valid, out_last, out_is_dc, is_luminance});
      end
      checks++;
      if ({out_code, out_len, ac_index, dc_diff} !== '0) begin
         errors++; $display("FAIL reset_data code=%h len=%0d idx=%0d diff=%h required 0",
                            out_code, out_len, ac_index, dc_diff);
      end
      checks++;
      if (coef_matrix !== '0) begin
         errors++; $display("FAIL reset_coef_matrix nonzero required 0");
      end
   endtask

   // coef0=+12, all AC zero, predictor 0: DC then EOB
   task automatic test_dc_basic(input string tag);
      int base; logic [30:0] ex [2];
      clear_coefs(); tb_coef[0] = 10'd12;
      ex[0] = mk(16'h000C, 9, 1, 0, 0);
      ex[1] = mk(16'h000A, 4, 0, 1, 1);
      run_block(0, 1'b0, base);
      checks++;
      if (n_log - base !== 2) begin
         errors++; $display("FAIL %s_count got=%0d required 2", tag, n_log - base);
      end
      checks++;
      if (lg_diff[base] !== 11'd12) begin
         errors++; $display("FAIL %s_dc_diff got=%0d required 12", tag, $signed(lg_diff[base]));
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (lg[base+i] !== ex[i]) begin
            errors++; $display("FAIL %s_word%0d got=%h required %h", tag, i, lg[base+i], ex[i]);
         end
      end
   endtask

   // Predictor per component, dc_clear alone and together with start, comp_id 3 -> 0
   task automatic test_predictor();
      int comps [5] = '{0, 1, 0, 0, 3};
      bit pre_clr [5] = '{0, 0, 1, 0, 0};
      bit sim_clr [5] = '{0, 0, 0, 1, 0};
      int c0 [5] = '{5, 5, 5, 5, 9};
      int exd [5] = '{-7, 5, 5, 5, 4};
      int base;
      for (int t = 0; t < 5; t++) begin
         clear_coefs(); tb_coef[0] = 10'(c0[t]);
         if (pre_clr[t]) begin
            @(posedge clock); #1 dc_clear = 1'b1;
            @(posedge clock); #1 dc_clear = 1'b0;
         end
         run_block(comps[t], sim_clr[t], base);
         checks++;
         if (lg_diff[base] !== 11'(exd[t]) || lg[base] !== mk(16'(exd[t]), 9, 1, 0, 0)) begin
            errors++; $display("FAIL pred_case%0d diff=%0d word=%h required diff=%0d word=%h",
                               t, $signed(lg_diff[base]), lg[base], exd[t], mk(16'(exd[t]), 9, 1, 0, 0));
         end
      end
   endtask

   // Nonzero AC at k=3 and k=63: index 1,4 then ZRLs to 52, last at k=63, no EOB
   task automatic test_ac_sparse();
      int base; logic [30:0] ex [6];
      clear_coefs(); tb_coef[0] = 10'd9; tb_coef[3] = 10'd7; tb_coef[63] = 10'h3FD;
      ex[0] = mk(16'h0000, 9, 1, 0, 0);
      ex[1] = mk(16'hA203, 3, 0, 0, 1);
      ex[2] = mk(16'h07F9, 11, 0, 0, 4);
      ex[3] = mk(16'h07F9, 11, 0, 0, 20);
      ex[4] = mk(16'h07F9, 11, 0, 0, 36);
      ex[5] = mk(16'hAB3F, 12, 0, 1, 52);
      run_block(0, 1'b0, base);
      checks++;
      if (n_log - base !== 6) begin
         errors++; $display("FAIL sparse_count got=%0d required 6", n_log - base);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (lg[base+i] !== ex[i]) begin
            errors++; $display("FAIL sparse_word%0d got=%h required %h", i, lg[base+i], ex[i]);
         end
      end
   endtask

   // 20 zeros then nonzero at k=21: ZRL at 1, coded at 17 (run 4), EOB at 22
   task automatic test_zrl();
      int base; logic [30:0] ex [4];
      clear_coefs(); tb_coef[0] = 10'd9; tb_coef[21] = 10'd2;
      ex[0] = mk(16'h0000, 9, 1, 0, 0);
      ex[1] = mk(16'h07F9, 11, 0, 0, 1);
      ex[2] = mk(16'hA415, 5, 0, 0, 17);
      ex[3] = mk(16'h000A, 4, 0, 1, 22);
      run_block(0, 1'b0, base);
      checks++;
      if (n_log - base !== 4) begin
         errors++; $display("FAIL zrl_count got=%0d required 4", n_log - base);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lg[base+i] !== ex[i]) begin
            errors++; $display("FAIL zrl_word%0d got=%h required %h", i, lg[base+i], ex[i]);
         end
      end
   endtask

   // out_ready low 10 cycles on an AC codeword; a start pulse meanwhile is ignored
   task automatic test_backpressure();
      int base; bit seen; logic [30:0] ex [3]; logic [30:0] snap, now;
      clear_coefs(); tb_coef[0] = 10'd9; tb_coef[5] = 10'd3;
      ex[0] = mk(16'h0000, 9, 1, 0, 0);
      ex[1] = mk(16'hA405, 5, 0, 0, 1);
      ex[2] = mk(16'h000A, 4, 0, 1, 6);
      base = n_log;
      @(posedge clock); #1; out_ready = 1'b0; start = 1'b1; comp_id = 2'd0;
      @(posedge clock); #1; start = 1'b0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin @(negedge clock); seen = out_valid; end
      @(posedge clock); #1 out_ready = 1'b1;
      @(posedge clock); #1 out_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin @(negedge clock); seen = out_valid; end
      snap = {out_code, out_len, out_is_dc, out_valid, ac_index};
      checks++;
      if (snap !== {16'hA405, 5'd5, 1'b0, 1'b1, 8'd1}) begin
         errors++; $display("FAIL stall_first got=%h required %h", snap,
                            {16'hA405, 5'd5, 1'b0, 1'b1, 8'd1});
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1; start = (i == 3); comp_id = 2'd1;
         @(negedge clock);
         now = {out_code, out_len, out_is_dc, out_valid, ac_index};
         checks++;
         if (now !== snap) begin
            errors++; $display("FAIL stall_hold cycle%0d got=%h required %h", i, now, snap);
         end
      end
      @(posedge clock); #1; start = 1'b0; comp_id = 2'd0; out_ready = 1'b1;
      wait_idle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (lg[base+i] !== ex[i]) begin
            errors++; $display("FAIL stall_word%0d got=%h required %h", i, lg[base+i], ex[i]);
         end
      end
      repeat (20) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || n_log - base !== 3) begin
         errors++; $display("FAIL stall_start_ignored busy=%0b words=%0d required busy=0 words=3",
                            busy, n_log - base);
      end
   endtask

   // Reset in AC_WAIT: outputs clear, no partial block, predictors cleared
   task automatic test_reset_mid_block();
      int base; bit seen;
      clear_coefs(); tb_coef[0] = 10'd30; tb_coef[10] = 10'd1;
      base = n_log;
      @(posedge clock); #1; start = 1'b1; comp_id = 2'd0;
      @(posedge clock); #1; start = 1'b0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clock); seen = busy && !out_valid && ac_index == 8'd1;
      end
      @(negedge clock);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({busy, out_valid, out_last, out_is_dc, is_luminance, out_code, out_len, ac_index,
           dc_diff} !== '0 || coef_matrix !== '0) begin
         errors++; $display("FAIL midreset_outputs busy=%0b valid=%0b code=%h idx=%0d diff=%h required 0",
                            busy, out_valid, out_code, ac_index, dc_diff);
      end
      checks++;
      if (n_log - base !== 1) begin
         errors++; $display("FAIL midreset_words got=%0d required 1", n_log - base);
      end
      test_dc_basic("after_reset");
   endtask

   initial begin
      clear_coefs();
      test_reset();
      test_dc_basic("first");
      test_predictor();
      test_ac_sparse();
      test_zrl();
      test_backpressure();
      test_reset_mid_block();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
`default_nettype wire
